photo_tape_reader_emu: RTL and testbench

// - Peripheral end of the built-in phototape interface: emulates the G-15 photoelectric reader.
// - Holds a host-loaded tape image (5-bit frames) and advances it while the I/O section drives

---
 rtl/photo_tape_pkg.sv | 22 ++
 rtl/tape_image_ram.sv | 25 ++
 rtl/photo_tape_reader_emu.sv | 139 +++++++++++++
 tb/tb_photo_tape_reader_emu.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/photo_tape_pkg.sv
// Shared types for the phototape reader emulator: frame type, reader states, and
// move-command decode.
package photo_tape_pkg;

   localparam int FRAME_W = 5;

   typedef logic [FRAME_W-1:0] tape_frame_t;

   typedef enum logic [1:0] {STOP, RUN_F, RUN_R} ptr_state_t;

   typedef enum logic [1:0] {CMD_STOP, CMD_FWD, CMD_REV} tape_cmd_t;

   // Both lines active together is treated as no command.
   function automatic tape_cmd_t decode_cmd(input logic fwd, input logic rev);
      case ({fwd, rev})
         2'b10:   return CMD_FWD;
         2'b01:   return CMD_REV;
         default: return CMD_STOP;
      endcase
   endfunction

endpackage

// File: rtl/tape_image_ram.sv
// Tape image store: one write port, one registered read port; no reset so it maps
// onto block RAM.
module tape_image_ram
   import photo_tape_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input  logic               CLOCK,
   input  logic               wr_en,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [FRAME_W-1:0] wr_data,
   input  logic [ADDR_W-1:0]  rd_addr,
   output logic [FRAME_W-1:0] rd_data
);

   tape_frame_t mem [2**ADDR_W];

   always_ff @(posedge CLOCK) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/photo_tape_reader_emu.sv
// G-15 photoelectric reader emulator: steps a host-loaded tape image forward or back one
// frame per period and shows each frame's holes on PHOTO1..5 inside a fixed window.
module photo_tape_reader_emu
   import photo_tape_pkg::*;
#(
   parameter int ADDR_W     = 12,
   parameter int FRAME_CLKS = 80000,
   parameter int HOLE_START = 20000,
   parameter int HOLE_END   = 60000
) (
   input  logic               CLOCK,
   input  logic               rst_n,
   input  logic               PHOTO_TAPE_FWD,
   input  logic               PHOTO_TAPE_REV,
   output logic               PHOTO1,
   output logic               PHOTO2,
   output logic               PHOTO3,
   output logic               PHOTO4,
   output logic               PHOTO5,
   input  logic               load_clear,
   input  logic               load_valid,
   input  logic [FRAME_W-1:0] load_data,
   output logic               load_ready,
   input  logic               rewind,
   output logic [ADDR_W:0]    tape_len,
   output logic [ADDR_W:0]    tape_pos,
   output logic               at_bot,
   output logic               at_eot
);

   localparam int TIMER_W = $clog2(FRAME_CLKS);
   localparam logic [TIMER_W-1:0] LAST_TICK  = TIMER_W'(FRAME_CLKS - 1);
   localparam logic [TIMER_W-1:0] WIN_START  = TIMER_W'(HOLE_START);
   localparam logic [TIMER_W-1:0] WIN_END    = TIMER_W'(HOLE_END);
   localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
   localparam logic [ADDR_W:0]    POS_ONE    = (ADDR_W+1)'(1);

   ptr_state_t          state_reg, state_next;
   logic [TIMER_W-1:0]  timer_reg, timer_next;
   logic [ADDR_W:0]     pos_reg, pos_next, pos_step;
   logic [ADDR_W:0]     len_reg, len_next;
   tape_frame_t         photo_reg, photo_next;
   tape_frame_t         rd_data;
   logic [ADDR_W-1:0]   rd_addr;
   logic                wr_en;
   logic                boundary;
   logic                sample;
   logic                in_window;
   tape_cmd_t           cmd;

   assign cmd      = decode_cmd(PHOTO_TAPE_FWD, PHOTO_TAPE_REV);
   assign boundary = (timer_reg == LAST_TICK);

   always_ff @(posedge CLOCK or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= STOP;
      end else begin
         state_reg <= state_next;
      end
   end

   // pos_step is the position the tape will be at after the current frame finishes.
   always_comb begin
      pos_step = pos_reg;
      if (state_reg == RUN_F) begin
         pos_step = pos_reg + POS_ONE;
      end else if (state_reg == RUN_R) begin
         pos_step = pos_reg - POS_ONE;
      end
      sample     = (state_reg == STOP) ? !(load_clear || rewind) : boundary;
      state_next = state_reg;
      if (sample) begin
         if (cmd == CMD_FWD && pos_step < len_reg) begin
            state_next = RUN_F;
         end else if (cmd == CMD_REV && pos_step != '0) begin
            state_next = RUN_R;
         end else begin
            state_next = STOP;
         end
      end
   end

   always_comb begin
      load_ready = (state_reg == STOP) && !len_reg[ADDR_W];
      wr_en      = load_valid && load_ready && !load_clear;
      len_next   = len_reg;
      pos_next   = pos_reg;
      if (state_reg == STOP) begin
         if (load_clear) begin
            len_next = '0;
            pos_next = '0;
         end else begin
            if (wr_en) begin
               len_next = len_reg + POS_ONE;
            end
            if (rewind) begin
               pos_next = '0;
            end
         end
      end else if (boundary) begin
         pos_next = pos_step;
      end
      timer_next = (state_reg == STOP || boundary) ? '0 : timer_reg + TIMER_ONE;
      rd_addr    = (state_reg == RUN_R) ? pos_step[ADDR_W-1:0] : pos_reg[ADDR_W-1:0];
      // Decided one cycle ahead so the registered PHOTO lines line up with the timer.
      in_window  = (state_next != STOP) && (timer_next >= WIN_START) && (timer_next < WIN_END);
      photo_next = in_window ? rd_data : '0;
   end

   always_ff @(posedge CLOCK or negedge rst_n) begin
      if (!rst_n) begin
         timer_reg <= '0;
         pos_reg   <= '0;
         len_reg   <= '0;
         photo_reg <= '0;
      end else begin
         timer_reg <= timer_next;
         pos_reg   <= pos_next;
         len_reg   <= len_next;
         photo_reg <= photo_next;
      end
   end

   tape_image_ram #(.ADDR_W(ADDR_W)) u_image (
      .CLOCK   (CLOCK),
      .wr_en   (wr_en),
      .wr_addr (len_reg[ADDR_W-1:0]),
      .wr_data (load_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   assign {PHOTO5, PHOTO4, PHOTO3, PHOTO2, PHOTO1} = photo_reg;
   assign tape_len = len_reg;
   assign tape_pos = pos_reg;
   assign at_bot   = (pos_reg == '0);
   assign at_eot   = (pos_reg == len_reg);

endmodule

// File: tb/tb_photo_tape_reader_emu.sv
// Bench for photo_tape_reader_emu: directed scenarios plus randomized command sequences,
// all compared cycle by cycle against a frame-level tape model.
module tb_photo_tape_reader_emu;

   localparam int AW  = 4;
   localparam int FC  = 20;
   localparam int HS  = 5;
   localparam int HE  = 15;
   localparam int CAP = 16;

   logic CLOCK = 0;
   logic rst_n = 0;
   logic fwd = 0, rev = 0, lc = 0, lv = 0, rw = 0;
   logic [4:0] ld = '0;
   logic photo1, photo2, photo3, photo4, photo5;
   logic load_ready, at_bot, at_eot;
   logic [AW:0] tape_len, tape_pos;
   wire  [4:0] photo = {photo5, photo4, photo3, photo2, photo1};

   int checks = 0;
   int errors = 0;

   // Reference model: tape image, length, position, and the frame currently passing the head.
   logic [4:0] m_img [CAP];
   int m_len = 0, m_pos = 0, m_phase = 0, m_dir = 1;
   bit m_busy = 0;

   photo_tape_reader_emu #(.ADDR_W(AW), .FRAME_CLKS(FC), .HOLE_START(HS), .HOLE_END(HE)) dut (
      .CLOCK(CLOCK), .rst_n(rst_n), .PHOTO_TAPE_FWD(fwd), .PHOTO_TAPE_REV(rev),
      .PHOTO1(photo1), .PHOTO2(photo2), .PHOTO3(photo3), .PHOTO4(photo4), .PHOTO5(photo5),
      .load_clear(lc), .load_valid(lv), .load_data(ld), .load_ready(load_ready),
      .rewind(rw), .tape_len(tape_len), .tape_pos(tape_pos), .at_bot(at_bot), .at_eot(at_eot)
   );

   always #5 CLOCK = ~CLOCK;

   function automatic void m_decide();
      if (fwd && !rev && m_pos < m_len) begin
         m_busy = 1; m_dir = 1;
      end else if (rev && !fwd && m_pos > 0) begin
         m_busy = 1; m_dir = -1;
      end else begin
         m_busy = 0;
      end
      m_phase = 0;
   endfunction

   function automatic void m_step();
      bit was_busy;
      was_busy = m_busy;
      if (!was_busy) begin
         if (!(lc || rw)) m_decide();
         if (lc) begin
            m_len = 0; m_pos = 0;
         end else begin
            if (lv && m_len < CAP) begin
               m_img[m_len] = ld; m_len++;
            end
            if (rw) m_pos = 0;
         end
      end else if (m_phase == FC - 1) begin
         m_pos += m_dir;
         m_decide();
      end else begin
         m_phase++;
      end
   endfunction

   function automatic logic [4:0] m_photo();
      if (m_busy && m_phase >= HS && m_phase < HE)
         return m_img[(m_dir > 0) ? m_pos : m_pos - 1];
      return 5'h00;
   endfunction

   function automatic void m_reset();
      m_busy = 0; m_pos = 0; m_len = 0; m_phase = 0;
   endfunction

   task automatic cycle();
      @(posedge CLOCK);
      m_step();
      @(negedge CLOCK);
   endtask

   task automatic test_reset();
      @(negedge CLOCK);
      @(negedge CLOCK);
      if (photo !== 5'h00) begin errors++; $display("FAIL reset_photo got %h want 00", photo); end
      checks++;
      rst_n = 1;
      @(negedge CLOCK);
      if (tape_pos !== '0 || tape_len !== '0) begin
         errors++; $display("FAIL reset_counters got pos %0d len %0d want 0 0", tape_pos, tape_len);
      end
      checks++;
      if ({load_ready, at_bot, at_eot} !== 3'b111) begin
         errors++; $display("FAIL reset_flags got rdy/bot/eot %b want 111", {load_ready, at_bot, at_eot});
      end
      checks++;
   endtask

   task automatic test_load();
      logic [4:0] frames [3];
      frames[0] = 5'h1F; frames[1] = 5'h01; frames[2] = 5'h10;
      for (int i = 0; i < 3; i++) begin
         lv = 1; ld = frames[i];
         cycle();
         if (tape_len !== 5'(i + 1)) begin
            errors++; $display("FAIL load_len got %0d want %0d", tape_len, i + 1);
         end
         checks++;
      end
      lv = 0;
   endtask

   task automatic test_single_pulse();
      int ones = 0;
      fwd = 1;
      cycle();
      fwd = 0;
      for (int i = 0; i < 26; i++) begin
         if (photo !== m_photo()) begin
            errors++; $display("FAIL pulse_photo cyc %0d got %h want %h", i, photo, m_photo());
         end
         checks++;
         if (photo === 5'h1F) ones++;
         cycle();
      end
      if (ones != 10) begin errors++; $display("FAIL pulse_window got %0d cycles want 10", ones); end
      checks++;
      if (tape_pos !== 5'd1) begin errors++; $display("FAIL pulse_pos got %0d want 1", tape_pos); end
      checks++;
   endtask

   task automatic test_hold_fwd();
      rw = 1;
      cycle();
      rw = 0;
      if (tape_pos !== 5'd0) begin errors++; $display("FAIL rewind_pos got %0d want 0", tape_pos); end
      checks++;
      fwd = 1;
      for (int i = 0; i < 3 * FC + 25; i++) begin
         cycle();
         if (photo !== m_photo()) begin
            errors++; $display("FAIL fwd_photo cyc %0d got %h want %h", i, photo, m_photo());
         end
         checks++;
      end
      fwd = 0;
      if (tape_pos !== 5'd3 || at_eot !== 1'b1) begin
         errors++; $display("FAIL fwd_eot got pos %0d eot %b want 3 1", tape_pos, at_eot);
      end
      checks++;
   endtask

   task automatic test_hold_rev();
      rev = 1;
      for (int i = 0; i < 3 * FC + 25; i++) begin
         cycle();
         if (photo !== m_photo()) begin
            errors++; $display("FAIL rev_photo cyc %0d got %h want %h", i, photo, m_photo());
         end
         checks++;
      end
      rev = 0;
      if (tape_pos !== 5'd0 || at_bot !== 1'b1) begin
         errors++; $display("FAIL rev_bot got pos %0d bot %b want 0 1", tape_pos, at_bot);
      end
      checks++;
   endtask

   task automatic test_swap();
      int guard = 0;
      int ones = 0;
      fwd = 1;
      while (!(m_busy && m_pos == 1 && m_phase == 8) && guard < 100) begin
         cycle(); guard++;
         if (photo !== m_photo()) begin errors++; $display("FAIL swap_photo_a got %h want %h", photo, m_photo()); end
         checks++;
         if (photo === 5'h01) ones++;
      end
      fwd = 0; rev = 1; guard = 0;
      while (!(m_busy && m_dir < 0) && guard < 60) begin
         cycle(); guard++;
         if (photo !== m_photo()) begin errors++; $display("FAIL swap_photo_b got %h want %h", photo, m_photo()); end
         checks++;
         if (photo === 5'h01) ones++;
      end
      if (tape_pos !== 5'd2) begin errors++; $display("FAIL swap_mid_pos got %0d want 2", tape_pos); end
      checks++;
      rev = 0; guard = 0;
      while (m_busy && guard < 60) begin
         cycle(); guard++;
         if (photo !== m_photo()) begin errors++; $display("FAIL swap_photo_c got %h want %h", photo, m_photo()); end
         checks++;
         if (photo === 5'h01) ones++;
      end
      if (guard >= 60) begin errors++; $display("FAIL swap_timeout got %0d cycles want < 60", guard); end
      checks++;
      if (tape_pos !== 5'd1 || ones != 20) begin
         errors++; $display("FAIL swap_end got pos %0d win %0d want 1 20", tape_pos, ones);
      end
      checks++;
   endtask

   task automatic test_both_cmds();
      fwd = 1; rev = 1;
      for (int i = 0; i < 25; i++) begin
         cycle();
         if (photo !== 5'h00 || tape_pos !== 5'd1) begin
            errors++; $display("FAIL both_idle cyc %0d got photo %h pos %0d want 00 1", i, photo, tape_pos);
         end
         checks++;
      end
      lv = 1; ld = 5'(($urandom % 30) + 1);
      cycle();
      lv = 0;
      if (tape_len !== 5'd4) begin errors++; $display("FAIL both_load got %0d want 4", tape_len); end
      checks++;
      rw = 1;
      cycle();
      rw = 0;
      if (tape_pos !== 5'd0) begin errors++; $display("FAIL both_rewind got %0d want 0", tape_pos); end
      checks++;
      fwd = 0; rev = 0;
   endtask

   task automatic test_reset_mid_frame();
      int guard = 0;
      fwd = 1;
      while (!(m_busy && m_pos == 2 && m_phase == 10) && guard < 100) begin
         cycle(); guard++;
      end
      if (photo !== 5'h10) begin errors++; $display("FAIL rst_pre_photo got %h want 10", photo); end
      checks++;
      rst_n = 0;
      #1;
      if (photo !== 5'h00 || tape_pos !== '0 || tape_len !== '0) begin
         errors++; $display("FAIL rst_async got photo %h pos %0d len %0d want 00 0 0", photo, tape_pos, tape_len);
      end
      checks++;
      m_reset();
      @(negedge CLOCK);
      rst_n = 1;
      cycle();
      if (load_ready !== 1'b1 || photo !== 5'h00) begin
         errors++; $display("FAIL rst_release got rdy %b photo %h want 1 00", load_ready, photo);
      end
      checks++;
      fwd = 0;
   endtask

   task automatic test_random();
      int n;
      fwd = 1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         if (load_ready !== 1'b1 || tape_pos !== '0 || photo !== 5'h00) begin
            errors++; $display("FAIL empty_stop got rdy %b pos %0d photo %h want 1 0 00", load_ready, tape_pos, photo);
         end
         checks++;
      end
      fwd = 0;
      n = $urandom_range(8, CAP);
      for (int i = 0; i < n + 1; i++) begin
         lv = 1; ld = 5'($urandom);
         cycle();
         if (tape_len !== 5'(m_len) || load_ready !== (m_len < CAP)) begin
            errors++; $display("FAIL rnd_load got len %0d rdy %b want %0d %b", tape_len, load_ready, m_len, m_len < CAP);
         end
         checks++;
      end
      lv = 0;
      for (int s = 0; s < 30; s++) begin
         int c;
         int hold;
         c = $urandom_range(0, 3);
         hold = $urandom_range(1, 50);
         fwd = c[1]; rev = c[0];
         for (int i = 0; i < hold; i++) begin
            lv = ($urandom_range(0, 3) == 0);
            rw = ($urandom_range(0, 15) == 0);
            ld = 5'($urandom);
            cycle();
            if (photo !== m_photo() || tape_pos !== 5'(m_pos) || tape_len !== 5'(m_len)) begin
               errors++; $display("FAIL rnd_cycle seg %0d got photo %h pos %0d len %0d want %h %0d %0d",
                                  s, photo, tape_pos, tape_len, m_photo(), m_pos, m_len);
            end
            checks++;
            if (load_ready !== (!m_busy && m_len < CAP) || at_eot !== (m_pos == m_len)) begin
               errors++; $display("FAIL rnd_flags seg %0d got rdy %b eot %b", s, load_ready, at_eot);
            end
            checks++;
         end
      end
      fwd = 0; rev = 0; lv = 0; rw = 0;
   endtask

   initial begin
      for (int i = 0; i < CAP; i++) m_img[i] = 5'h00;
      test_reset();
      test_load();
      test_single_pulse();
      test_hold_fwd();
      test_hold_rev();
      test_swap();
      test_both_cmds();
      test_reset_mid_frame();
      lc = 1;
      cycle();
      lc = 0;
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
